// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_e;

   localparam int unsigned DEF_MULT_LAT = 4;
   localparam int unsigned DEF_DIV_LAT  = 12;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and register-control outputs of the pipeline sequencer.
// master = pipeline datapath side, slave = the sequencer itself.
interface pipeline_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_memread;
   logic [4:0]       ex_rt;
   logic             ex_branch_taken;
   logic             ex_md_start;
   logic             ex_md_is_div;
   logic             mem_busy;

   logic             pc_ld;
   logic             if_id_ld;
   logic             id_ex_ld;
   logic             ex_mem_ld;
   logic             mem_wb_ld;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             md_busy;
   logic             md_done;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken,
             ex_md_start, ex_md_is_div, mem_busy,
      input  pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld,
             if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_done, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken,
             ex_md_start, ex_md_is_div, mem_busy,
      output pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld,
             if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_done, stall_count
   );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard comparator: the ID instruction reads the register a load in EX
// is about to write. r0 never creates a dependency.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] i_id_rs,
   input  logic [4:0] i_id_rt,
   input  logic       i_id_uses_rt,
   input  logic       i_ex_memread,
   input  logic [4:0] i_ex_rt,
   output logic       o_hazard
);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (i_id_rs == i_ex_rt);
   assign w_rt_match = i_id_uses_rt && (i_id_rt == i_ex_rt);
   assign o_hazard   = i_ex_memread && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Produces register load
// enables and bubble strobes from the hazard sources, tracks multi-cycle mult/div
// occupancy of EX, and counts front-end stall cycles.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = DEF_MULT_LAT,
   parameter int unsigned DIV_LAT  = DEF_DIV_LAT,
   parameter int unsigned CNT_W    = 32
) (
   input logic             clk,
   input logic             reset,
   pipeline_ctrl_if.slave  bus
);

   localparam int unsigned MD_W = $clog2(max_u(MULT_LAT, DIV_LAT)) + 1;

   // Reload values are only used when the matching latency exceeds one cycle.
   localparam logic [MD_W-1:0] MULT_RELOAD = MD_W'(MULT_LAT - 2);
   localparam logic [MD_W-1:0] DIV_RELOAD  = MD_W'(DIV_LAT - 2);

   // Load-enable vectors, ordered {pc, if_id, id_ex, ex_mem, mem_wb}.
   localparam logic [4:0] LD_NONE = 5'b00000;
   localparam logic [4:0] LD_ALL  = 5'b11111;
   localparam logic [4:0] LD_MD   = 5'b00011;
   localparam logic [4:0] LD_LU   = 5'b00111;

   // Flush vectors, ordered {if_id, id_ex, ex_mem}.
   localparam logic [2:0] FL_NONE   = 3'b000;
   localparam logic [2:0] FL_BRANCH = 3'b110;
   localparam logic [2:0] FL_LU     = 3'b010;
   localparam logic [2:0] FL_MD     = 3'b001;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [MD_W-1:0]  r_md_cnt;
   logic [MD_W-1:0]  w_md_cnt_nxt;
   logic [CNT_W-1:0] r_stall_count;

   logic [4:0]       w_ld;
   logic [2:0]       w_flush;
   logic             w_md_busy;
   logic             w_md_done;
   logic             w_hazard;
   logic             w_lat_one;

   load_use_detect u_load_use_detect (
      .i_id_rs      (bus.id_rs),
      .i_id_rt      (bus.id_rt),
      .i_id_uses_rt (bus.id_uses_rt),
      .i_ex_memread (bus.ex_memread),
      .i_ex_rt      (bus.ex_rt),
      .o_hazard     (w_hazard)
   );

   assign w_lat_one = bus.ex_md_is_div ? (DIV_LAT == 1) : (MULT_LAT == 1);

   // Hazard resolution: outputs and next state from state, md_cnt and inputs.
   always_comb begin
      w_ld         = LD_NONE;
      w_flush      = FL_NONE;
      w_md_busy    = 1'b0;
      w_md_done    = 1'b0;
      w_state_nxt  = r_state;
      w_md_cnt_nxt = r_md_cnt;

      if (!reset) begin
         unique case (r_state)
            RUN: begin
               if (bus.mem_busy) begin
                  // Full freeze; pending hazards are re-evaluated when MEM releases.
               end else if (bus.ex_md_start) begin
                  if (w_lat_one) begin
                     w_ld      = LD_ALL;
                     w_md_done = 1'b1;
                  end else begin
                     // Older instructions drain; a bubble enters EX_MEM behind them.
                     w_ld         = LD_MD;
                     w_flush      = FL_MD;
                     w_md_busy    = 1'b1;
                     w_state_nxt  = MD_BUSY;
                     w_md_cnt_nxt = bus.ex_md_is_div ? DIV_RELOAD : MULT_RELOAD;
                  end
               end else if (bus.ex_branch_taken) begin
                  // Wins over load-use: the ID instruction is discarded anyway.
                  w_ld    = LD_ALL;
                  w_flush = FL_BRANCH;
               end else if (w_hazard) begin
                  w_ld    = LD_LU;
                  w_flush = FL_LU;
               end else begin
                  w_ld = LD_ALL;
               end
            end
            MD_BUSY: begin
               w_md_busy = 1'b1;
               if (bus.mem_busy) begin
                  // The MD unit keeps counting while MEM freezes the pipeline.
                  if (r_md_cnt != '0) begin
                     w_md_cnt_nxt = r_md_cnt - MD_W'(1);
                  end
               end else if (r_md_cnt != '0) begin
                  w_ld         = LD_MD;
                  w_flush      = FL_MD;
                  w_md_cnt_nxt = r_md_cnt - MD_W'(1);
               end else begin
                  // EX still holds the MD instruction, so branch/load-use are ignored.
                  w_ld        = LD_ALL;
                  w_md_done   = 1'b1;
                  w_state_nxt = RUN;
               end
            end
            default: begin
               w_state_nxt = RUN;
            end
         endcase
      end
   end

   // Sequencer state and mult/div countdown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= RUN;
         r_md_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_md_cnt <= w_md_cnt_nxt;
      end
   end

   // Saturating count of cycles in which the PC did not advance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_count <= '0;
      end else if (!w_ld[4] && !(&r_stall_count)) begin
         r_stall_count <= r_stall_count + CNT_W'(1);
      end
   end

   assign bus.pc_ld        = w_ld[4];
   assign bus.if_id_ld     = w_ld[3];
   assign bus.id_ex_ld     = w_ld[2];
   assign bus.ex_mem_ld    = w_ld[1];
   assign bus.mem_wb_ld    = w_ld[0];
   assign bus.if_id_flush  = w_flush[2];
   assign bus.id_ex_flush  = w_flush[1];
   assign bus.ex_mem_flush = w_flush[0];
   assign bus.md_busy      = w_md_busy;
   assign bus.md_done      = w_md_done;
   assign bus.stall_count  = r_stall_count;

endmodule
